hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/hazard_ctrl_if.sv | 34 +++
 rtl/hazard_detect.sv | 29 ++
 rtl/hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared pipeline-control types and constants
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when rd is a real (non-zero) register read by either ID source.
  function automatic logic reg_hit(input logic [4:0] rd, input logic [4:0] rs,
                                   input logic [4:0] rt);
    return (rd != REG_ZERO) && ((rd == rs) || (rd == rt));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side signals of the hazard controller
interface hazard_ctrl_if;
  logic [4:0] ID_rs;
  logic [4:0] ID_rt;
  logic       ID_Branch;
  logic       ID_BranchTaken;
  logic       EX_MemRead;
  logic       EX_RegWrite;
  logic [4:0] EX_rd;
  logic       MEM_MemRead;
  logic [4:0] MEM_rd;
  logic       MEM_Access;
  logic       dmem_ready;
  logic       PC_Write;
  logic       IF_ID_Write;
  logic       ID_Flush;
  logic       ID_EX_Bubble;
  logic       EX_MEM_Write;
  logic       MEM_WB_Write;

  modport master (
    output ID_rs, ID_rt, ID_Branch, ID_BranchTaken, EX_MemRead, EX_RegWrite,
           EX_rd, MEM_MemRead, MEM_rd, MEM_Access, dmem_ready,
    input  PC_Write, IF_ID_Write, ID_Flush, ID_EX_Bubble, EX_MEM_Write,
           MEM_WB_Write
  );

  modport slave (
    input  ID_rs, ID_rt, ID_Branch, ID_BranchTaken, EX_MemRead, EX_RegWrite,
           EX_rd, MEM_MemRead, MEM_rd, MEM_Access, dmem_ready,
    output PC_Write, IF_ID_Write, ID_Flush, ID_EX_Bubble, EX_MEM_Write,
           MEM_WB_Write
  );
endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use and branch-operand hazard detection
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_branch,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_rd,
  input  logic       mem_mem_read,
  input  logic [4:0] mem_rd,
  output logic       lu_haz,
  output logic       br_haz,
  output logic       stall
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = reg_hit(ex_rd, id_rs, id_rt);
  assign mem_hit = reg_hit(mem_rd, id_rs, id_rt);

  assign lu_haz = ex_mem_read & ex_hit;
  // Branches resolve in ID, so they also wait on an EX ALU result or a MEM load.
  assign br_haz = id_branch & ((ex_reg_write & ex_hit) | (mem_mem_read & mem_hit));
  assign stall  = lu_haz | br_haz;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/freeze control with optional perf counters
// Optional feature macro: HAZARD_PERF_CNT_EN
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  hazard_ctrl_if.slave      pipe,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  state_t state;
  state_t state_next;
  logic   flush_pending;
  logic   flush_pending_next;
  logic   lu_haz;
  logic   br_haz;
  logic   stall;
  logic   freeze;
  logic   taken;
  logic   pc_write;
  logic   if_id_write;
  logic   id_flush;
  logic   id_ex_bubble;
  logic   ex_mem_write;
  logic   mem_wb_write;

  hazard_detect u_detect (
    .id_rs        (pipe.ID_rs),
    .id_rt        (pipe.ID_rt),
    .id_branch    (pipe.ID_Branch),
    .ex_mem_read  (pipe.EX_MemRead),
    .ex_reg_write (pipe.EX_RegWrite),
    .ex_rd        (pipe.EX_rd),
    .mem_mem_read (pipe.MEM_MemRead),
    .mem_rd       (pipe.MEM_rd),
    .lu_haz       (lu_haz),
    .br_haz       (br_haz),
    .stall        (stall)
  );

  // The cycle dmem_ready rises completes the access, so the pipeline advances then.
  assign freeze = ~pipe.dmem_ready & ((state == FREEZE) | pipe.MEM_Access);
  assign taken  = pipe.ID_Branch & pipe.ID_BranchTaken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      flush_pending <= 1'b0;
    end else begin
      state         <= state_next;
      flush_pending <= flush_pending_next;
    end
  end

  always_comb begin
    state_next         = state;
    flush_pending_next = flush_pending;
    pc_write           = 1'b1;
    if_id_write        = 1'b1;
    id_flush           = 1'b0;
    id_ex_bubble       = 1'b0;
    ex_mem_write       = 1'b1;
    mem_wb_write       = 1'b1;

    case (state)
      RUN:     if (pipe.MEM_Access && !pipe.dmem_ready) state_next = FREEZE;
      FREEZE:  if (pipe.dmem_ready) state_next = RUN;
      default: state_next = RUN;
    endcase

    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_flush     = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
    end else if (freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
      // A taken branch caught by the start of a freeze must still flush afterwards.
      if (state == RUN && taken && !stall) flush_pending_next = 1'b1;
    end else begin
      flush_pending_next = 1'b0;
      if (stall) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end else if (taken || flush_pending) begin
        id_flush = 1'b1;
      end
    end
  end

  assign pipe.PC_Write     = pc_write;
  assign pipe.IF_ID_Write  = if_id_write;
  assign pipe.ID_Flush     = id_flush;
  assign pipe.ID_EX_Bubble = id_ex_bubble;
  assign pipe.EX_MEM_Write = ex_mem_write;
  assign pipe.MEM_WB_Write = mem_wb_write;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall || freeze) stall_cycles <= stall_cycles + CNT_W'(1);
      if (id_flush)        flush_count  <= flush_count + CNT_W'(1);
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int CNT_W = 4;
  // Control vector order: PC_Write, IF_ID_Write, ID_Flush, ID_EX_Bubble, EX_MEM_Write, MEM_WB_Write
  localparam logic [5:0] C_NORM  = 6'b110011;
  localparam logic [5:0] C_STALL = 6'b000111;
  localparam logic [5:0] C_FLUSH = 6'b111011;
  localparam logic [5:0] C_FRZ   = 6'b000000;
  localparam logic [5:0] C_RST   = 6'b001100;

  logic clk;
  logic rst;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic [5:0] ctrl;
  logic [CNT_W-1:0] fc_before;
  int checks;
  int failures;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe         (bus),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  assign ctrl = {bus.PC_Write, bus.IF_ID_Write, bus.ID_Flush, bus.ID_EX_Bubble,
                 bus.EX_MEM_Write, bus.MEM_WB_Write};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ID_rs = 5'd0;          bus.ID_rt = 5'd0;
    bus.ID_Branch = 1'b0;      bus.ID_BranchTaken = 1'b0;
    bus.EX_MemRead = 1'b0;     bus.EX_RegWrite = 1'b0;     bus.EX_rd = 5'd0;
    bus.MEM_MemRead = 1'b0;    bus.MEM_rd = 5'd0;
    bus.MEM_Access = 1'b0;     bus.dmem_ready = 1'b1;
  endtask

  task automatic ctrl_is(input string tag, input logic [5:0] exp);
    #1;
    check(tag, {26'd0, ctrl}, {26'd0, exp});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clk = 1'b0;
    rst = 1'b1;
    clear_inputs();
    tick();
    ctrl_is("reset_outputs", C_RST);
    check("reset_stall_cycles", 32'(stall_cycles), 32'd0);
    check("reset_flush_count", 32'(flush_count), 32'd0);

    rst = 1'b0;
    ctrl_is("idle_normal", C_NORM);

    // Load-use: one bubble, then the load has moved to MEM and ID proceeds
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_rd = 5'd8; bus.ID_rs = 5'd8;
    ctrl_is("load_use_stall", C_STALL);
    tick();
    bus.EX_MemRead = 1'b0; bus.EX_RegWrite = 1'b0; bus.EX_rd = 5'd0;
    bus.MEM_MemRead = 1'b1; bus.MEM_rd = 5'd8;
    ctrl_is("load_use_resume", C_NORM);

    // Load-then-branch: stall with load in EX, again with load in MEM, then flush
    tick();
    clear_inputs();
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_rd = 5'd9;
    bus.ID_Branch = 1'b1; bus.ID_BranchTaken = 1'b1; bus.ID_rt = 5'd9;
    ctrl_is("ld_br_stall_ex", C_STALL);
    tick();
    bus.EX_MemRead = 1'b0; bus.EX_RegWrite = 1'b0; bus.EX_rd = 5'd0;
    bus.MEM_MemRead = 1'b1; bus.MEM_rd = 5'd9;
    ctrl_is("ld_br_stall_mem", C_STALL);
    tick();
    bus.MEM_MemRead = 1'b0; bus.MEM_rd = 5'd0;
    ctrl_is("ld_br_flush", C_FLUSH);
    tick();
    bus.ID_Branch = 1'b0; bus.ID_BranchTaken = 1'b0;
    ctrl_is("ld_br_after", C_NORM);

    // ALU result feeding an untaken branch: single stall, no flush afterwards
    tick();
    bus.EX_RegWrite = 1'b1; bus.EX_rd = 5'd3; bus.ID_Branch = 1'b1; bus.ID_rs = 5'd3;
    ctrl_is("alu_br_stall", C_STALL);
    tick();
    clear_inputs();
    bus.ID_Branch = 1'b1; bus.ID_rs = 5'd3;
    ctrl_is("alu_br_not_taken", C_NORM);

    // Freeze for three cycles; normal as soon as dmem_ready rises
    tick();
    clear_inputs();
    bus.MEM_Access = 1'b1; bus.dmem_ready = 1'b0;
    ctrl_is("freeze_c1", C_FRZ);
    tick();
    ctrl_is("freeze_c2", C_FRZ);
    tick();
    ctrl_is("freeze_c3", C_FRZ);
    tick();
    bus.dmem_ready = 1'b1;
    ctrl_is("freeze_release", C_NORM);
    tick();
    bus.MEM_Access = 1'b0; bus.dmem_ready = 1'b0;
    ctrl_is("freeze_done_run", C_NORM);

    // Deferred flush: taken branch present as freeze begins; flush lands after release
    tick();
    clear_inputs();
    fc_before = flush_count;
    bus.ID_Branch = 1'b1; bus.ID_BranchTaken = 1'b1;
    bus.MEM_Access = 1'b1; bus.dmem_ready = 1'b0;
    ctrl_is("defer_frz_c1", C_FRZ);
    tick();
    bus.ID_Branch = 1'b0; bus.ID_BranchTaken = 1'b0;
    ctrl_is("defer_frz_c2", C_FRZ);
    tick();
    bus.dmem_ready = 1'b1;
    ctrl_is("defer_flush", C_FLUSH);
    tick();
    bus.MEM_Access = 1'b0;
    ctrl_is("defer_cleared", C_NORM);
`ifdef HAZARD_PERF_CNT_EN
    check("defer_flush_count", 32'(flush_count), 32'((fc_before + 4'd1) & 4'hF));
`else
    check("defer_flush_count_tied", 32'(flush_count), 32'd0);
`endif

    // Reset mid-freeze with a pending flush
    tick();
    clear_inputs();
    bus.ID_Branch = 1'b1; bus.ID_BranchTaken = 1'b1;
    bus.MEM_Access = 1'b1; bus.dmem_ready = 1'b0;
    tick();
    rst = 1'b1;
    ctrl_is("rst_mid_freeze_out", C_RST);
    tick();
    rst = 1'b0;
    clear_inputs();
    bus.dmem_ready = 1'b0;
    ctrl_is("rst_mid_freeze_run", C_NORM);
    check("rst_mid_freeze_stall_cnt", 32'(stall_cycles), 32'd0);
    check("rst_mid_freeze_flush_cnt", 32'(flush_count), 32'd0);

    // Register zero never hazards
    tick();
    clear_inputs();
    bus.EX_MemRead = 1'b1; bus.EX_rd = 5'd0; bus.ID_rs = 5'd0;
    ctrl_is("zero_reg_load", C_NORM);
    bus.EX_RegWrite = 1'b1; bus.ID_Branch = 1'b1; bus.ID_BranchTaken = 1'b1;
    bus.MEM_MemRead = 1'b1; bus.MEM_rd = 5'd0;
    ctrl_is("zero_reg_branch", C_FLUSH);

    // 17 stall cycles on a 4-bit counter wrap to 1
    tick();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
    bus.EX_MemRead = 1'b1; bus.EX_rd = 5'd12; bus.ID_rt = 5'd12;
    for (int i = 0; i < 17; i++) tick();
    clear_inputs();
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt_wrap", 32'(stall_cycles), 32'd1);
`else
    check("stall_cnt_tied", 32'(stall_cycles), 32'd0);
`endif
    ctrl_is("final_normal", C_NORM);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
